ahb_master_if: RTL and testbench
================================

Name: ahb_master_if

Overview:
- Single-transfer AHB-Lite initiator that is the master side for the Data RAM slave (ram_ahb-style) and other slaves on the same bus.
- Accepts one read/write command at a time from a local controller through a valid/ready handshake.
- Runs the AHB address and data phases, including slave wait states, then returns one response (read data plus error flag).
- Non-pipelined: the address phase of one transfer never overlaps the data phase of another.

Parameters:
- ADDR_W, 32, width of command address and haddr.
- DATA_W, 32, width of write/read data buses; the only supported value is 32.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_size  in  3  AHB HSIZE encoding: 000 byte, 001 halfword, 010 word.
- cmd_wdata  in  DATA_W  write data, LSB-justified.
- rsp_valid  out  1  one-cycle pulse, transfer finished.
- rsp_rdata  out  DATA_W  read data, zero-extended per size; 0 for writes.
- rsp_err  out  1  transfer failed; qualified by rsp_valid.
- htrans  out  2  00 IDLE, 10 NONSEQ.
- haddr  out  ADDR_W  address-phase address.
- hwrite  out  1  address-phase direction.
- hsize  out  3  address-phase size.
- hwdata  out  DATA_W  data-phase write data.
- hrdata  in  DATA_W  slave read data.
- hready  in  1  slave ready / phase complete.

Behaviour:
- Reset:
  - State IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - htrans=00, haddr=0, hwrite=0, hsize=000, hwdata=0.
  - Reset mid-transfer drops the in-flight transfer; no response is produced.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture cmd_write, cmd_addr, cmd_size and cmd_wdata into internal registers.
  - Valid command: next state ADDR.
  - Illegal command: next state RESP with rsp_err=1, and no bus activity. Illegal means cmd_size>010, halfword with addr[0]=1, or word with addr[1:0]!=00.
- ADDR:
  - Drive htrans=10 with the captured haddr, hwrite and hsize; cmd_ready=0.
  - Stay while hready=0, holding all address signals stable.
  - On hready=1, go to DATA.
- DATA:
  - htrans=00.
  - For writes, hwdata=captured wdata, LSB-justified with no byte-lane steering (byte uses [7:0], halfword [15:0]).
  - hwdata is held stable until hready=1. For reads, hwdata=0.
  - On hready=1, latch hrdata masked to size: byte {24'b0,hrdata[7:0]}, halfword {16'b0,hrdata[15:0]}, word full. Then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata and rsp_err valid in the same cycle; cmd_ready=0.
  - Next state IDLE, where cmd_ready=1 and rsp_valid=0.
- Latency with zero wait states: 3 cycles from accept to rsp_valid (ADDR, DATA, RESP). Each hready=0 cycle adds one cycle.
- cmd_* inputs are ignored outside IDLE.
- rsp_rdata holds its last value until the next response.
- Address arithmetic never wraps inside the block; cmd_addr is passed through unmodified.

Optional Feature:
- Macro: AHB_MASTER_HRESP_EN.
- Defined:
  - Adds input hresp (1 bit, 1=ERROR).
  - In DATA, hresp=1 with hready=0 is the first error cycle; the block keeps htrans=00.
  - hresp=1 with hready=1 completes the transfer with rsp_err=1 and rsp_rdata=0.
  - hresp=1 during ADDR is ignored.
- Not defined: no hresp port; rsp_err=1 only for illegal commands.

Test Plan:
- Word read. Slave model preloaded with bytes 0xAA,0xBB,0xCC,0xDD,0xEE at addresses 0–4, no wait states. Read, addr 0, size 010 -> htrans=10 for 1 cycle, rsp_valid 3 cycles after accept, rsp_rdata=0xDDCCBBAA, rsp_err=0.
- Halfword read with wait states. Read, addr 2, size 001, slave holds hready=0 for 2 data-phase cycles -> rsp_valid 5 cycles after accept, rsp_rdata=0x0000DDCC.
- Byte write then read. Write, addr 4, size 000, wdata 0x12345678 -> hwdata=0x12345678 held through the data phase. Then read byte at addr 4 -> rsp_rdata=0x00000078.
- Misaligned command. Word write at addr 1 -> htrans stays 00, rsp_valid 1 cycle after accept with rsp_err=1. cmd_size=011 gives the same result.
- Reset mid-transfer. Assert reset during DATA of a write -> all outputs at reset values immediately, no rsp_valid, cmd_ready=1 after release.
- With AHB_MASTER_HRESP_EN defined: slave drives hresp=1/hready=0 then hresp=1/hready=1 -> rsp_valid with rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/ahb_master_if_if.sv
// Command/response and AHB-Lite bus bundle for ahb_master_if.
// hresp is present only when AHB_MASTER_HRESP_EN is defined.
interface ahb_master_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
`ifdef AHB_MASTER_HRESP_EN
  logic              hresp;
`endif

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output htrans, haddr, hwrite, hsize, hwdata,
    input  hrdata,
`ifdef AHB_MASTER_HRESP_EN
    input  hresp,
`endif
    input  hready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  htrans, haddr, hwrite, hsize, hwdata,
    output hrdata,
`ifdef AHB_MASTER_HRESP_EN
    output hresp,
`endif
    output hready
  );
endinterface

// File: rtl/ahb_master_if.sv
// Single-transfer, non-pipelined AHB-Lite initiator with a valid/ready command port.
// Define AHB_MASTER_HRESP_EN to honour slave ERROR responses on hresp.
module ahb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             reset,
  ahb_master_if_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cmd_legal;
  logic              data_err;
  logic [DATA_W-1:0] rdata_masked;

  always_comb begin
    case (bus.cmd_size)
      3'b000:  cmd_legal = 1'b1;
      3'b001:  cmd_legal = ~bus.cmd_addr[0];
      3'b010:  cmd_legal = (bus.cmd_addr[1:0] == 2'b00);
      default: cmd_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (hsize_q)
      3'b000:  rdata_masked = {{(DATA_W-8){1'b0}}, bus.hrdata[7:0]};
      3'b001:  rdata_masked = {{(DATA_W-16){1'b0}}, bus.hrdata[15:0]};
      default: rdata_masked = bus.hrdata;
    endcase
  end

`ifdef AHB_MASTER_HRESP_EN
  assign data_err = bus.hresp;
`else
  assign data_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_ready_d = 1'b0;
          if (cmd_legal) begin
            state_d  = S_ADDR;
            htrans_d = 2'b10;
            haddr_d  = bus.cmd_addr;
            hwrite_d = bus.cmd_write;
            hsize_d  = bus.cmd_size;
            wdata_d  = bus.cmd_wdata;
          end else begin
            // Illegal commands answer straight away without touching the bus
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      S_ADDR: begin
        if (bus.hready) begin
          state_d  = S_DATA;
          htrans_d = 2'b00;
          hwdata_d = hwrite_q ? wdata_q : '0;
        end
      end
      S_DATA: begin
        if (bus.hready) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = data_err;
          rsp_rdata_d = (data_err || hwrite_q) ? '0 : rdata_masked;
          hwdata_d    = '0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      htrans_q    <= 2'b00;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hwdata_q    <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.htrans    = htrans_q;
  assign bus.haddr     = haddr_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hsize     = hsize_q;
  assign bus.hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_master_if.sv
// Randomized bench for ahb_master_if: byte-array slave plus a golden memory reference.
// Build with AHB_MASTER_HRESP_EN defined to also exercise slave ERROR responses.
module tb_ahb_master_if;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] smem [256];
  logic [7:0] gmem [256];

  ahb_master_if_if bus ();
  ahb_master_if dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_legal(input int a, input int sz);
    if (sz == 0) return 1'b1;
    if (sz == 1) return (a % 2) == 0;
    if (sz == 2) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input int a, input int sz);
    int nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    logic [31:0] v = 32'd0;
    for (int k = 0; k < nbytes; k++) v = v + (32'(gmem[a + k]) << (8 * k));
    return v;
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = 3'b000;
    bus.cmd_wdata = '0;
    bus.hrdata    = '0;
    bus.hready    = 1'b1;
`ifdef AHB_MASTER_HRESP_EN
    bus.hresp     = 1'b0;
`endif
  endtask

  // Drives one command, plays the slave, and checks the response against the reference.
  task automatic run_txn(input bit wr, input int a, input int sz, input logic [31:0] wd,
                         input int aw, input int dw, input bit herr,
                         output int lat, output logic [31:0] rd, output bit er);
    bit legal, exp_err, in_data, done, err_step;
    int exp_lat, aw_left, dw_left, nbytes;
    logic [31:0] exp_rd;
    legal    = model_legal(a, sz);
    exp_err  = !legal || herr;
    exp_lat  = !legal ? 1 : 3 + aw + dw + (herr ? 1 : 0);
    exp_rd   = (exp_err || wr) ? 32'd0 : model_read(a, sz);
    nbytes   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    aw_left  = aw;
    dw_left  = dw;
    in_data  = 1'b0;
    done     = 1'b0;
    err_step = 1'b0;
    lat      = -1;
    rd       = 'x;
    er       = 1'bx;

    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_idle: got %b expected 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = 32'(a);
    bus.cmd_size  = 3'(sz);
    bus.cmd_wdata = wd;
    bus.hready    = 1'b1;
    @(negedge clk);
    // Garbage on the command port must be ignored while busy
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_size  = 3'($urandom_range(0, 7));
    bus.cmd_wdata = $urandom;

    for (int n = 1; n <= 60 && !done; n++) begin
      if (bus.rsp_valid === 1'b1) begin
        lat  = n;
        rd   = bus.rsp_rdata;
        er   = bus.rsp_err;
        done = 1'b1;
      end else begin
        if (bus.htrans === 2'b10) begin
          checks++;
          if (!legal || bus.haddr !== 32'(a) || bus.hwrite !== wr || bus.hsize !== 3'(sz)) begin
            errors++;
            $display("FAIL addr_phase: got haddr=%h hwrite=%b hsize=%0d expected legal=%b haddr=%h hwrite=%b hsize=%0d",
                     bus.haddr, bus.hwrite, bus.hsize, legal, a, wr, sz);
          end
`ifdef AHB_MASTER_HRESP_EN
          bus.hresp = 1'($urandom_range(0, 1));
`endif
          if (aw_left > 0) begin
            bus.hready = 1'b0;
            aw_left--;
          end else begin
            bus.hready = 1'b1;
            in_data = 1'b1;
          end
        end else if (in_data) begin
          checks++;
          if (bus.hwdata !== (wr ? wd : 32'd0)) begin
            errors++;
            $display("FAIL data_hwdata: got %h expected %h", bus.hwdata, wr ? wd : 32'd0);
          end
          bus.hrdata = {smem[a + 3], smem[a + 2], smem[a + 1], smem[a]};
`ifdef AHB_MASTER_HRESP_EN
          bus.hresp = 1'b0;
`endif
          if (dw_left > 0) begin
            bus.hready = 1'b0;
            dw_left--;
          end else if (herr && !err_step) begin
            bus.hready = 1'b0;
`ifdef AHB_MASTER_HRESP_EN
            bus.hresp  = 1'b1;
`endif
            err_step = 1'b1;
          end else begin
            bus.hready = 1'b1;
`ifdef AHB_MASTER_HRESP_EN
            bus.hresp  = herr;
`endif
            in_data = 1'b0;
            if (wr && !herr)
              for (int k = 0; k < nbytes; k++) smem[a + k] = bus.hwdata[8*k +: 8];
          end
        end else begin
          bus.hready = 1'b1;
`ifdef AHB_MASTER_HRESP_EN
          bus.hresp  = 1'b0;
`endif
          bus.hrdata = $urandom;
        end
        @(negedge clk);
      end
    end

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 60 cycles");
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL rsp_latency: got %0d expected %0d", lat, exp_lat);
    end
    checks++;
    if (rd !== exp_rd || er !== exp_err) begin
      errors++;
      $display("FAIL rsp_value: got rdata=%h err=%b expected rdata=%h err=%b", rd, er, exp_rd, exp_err);
    end
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL cmd_ready_resp: got %b expected 0", bus.cmd_ready);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_rdata !== rd) begin
      errors++;
      $display("FAIL rsp_pulse: got rsp_valid=%b cmd_ready=%b rdata=%h expected 0 1 %h",
               bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata, rd);
    end
    if (wr && !exp_err)
      for (int k = 0; k < nbytes; k++) gmem[a + k] = wd[8*k +: 8];
  endtask

  task automatic test_reset();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 ||
        bus.rsp_err !== 1'b0 || bus.htrans !== 2'b00 || bus.haddr !== 32'd0 ||
        bus.hwrite !== 1'b0 || bus.hsize !== 3'b000 || bus.hwdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b rv=%b rd=%h err=%b htrans=%b haddr=%h hw=%b hs=%b hwd=%h expected 1 0 0 0 00 0 0 000 0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.htrans,
               bus.haddr, bus.hwrite, bus.hsize, bus.hwdata);
    end
  endtask

  task automatic test_directed();
    int lat; logic [31:0] rd; bit er;
    run_txn(1'b0, 0, 2, 32'd0, 0, 0, 1'b0, lat, rd, er);
    checks++;
    if (rd !== 32'hDDCCBBAA || lat != 3) begin
      errors++;
      $display("FAIL word_read: got %h lat %0d expected ddccbbaa lat 3", rd, lat);
    end
    run_txn(1'b0, 2, 1, 32'd0, 0, 2, 1'b0, lat, rd, er);
    checks++;
    if (rd !== 32'h0000DDCC || lat != 5) begin
      errors++;
      $display("FAIL half_read_wait: got %h lat %0d expected 0000ddcc lat 5", rd, lat);
    end
    run_txn(1'b1, 4, 0, 32'h12345678, 0, 1, 1'b0, lat, rd, er);
    run_txn(1'b0, 4, 0, 32'd0, 0, 0, 1'b0, lat, rd, er);
    checks++;
    if (rd !== 32'h00000078) begin
      errors++;
      $display("FAIL byte_write_read: got %h expected 00000078", rd);
    end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] rd; bit er;
    run_txn(1'b1, 1, 2, 32'hCAFEF00D, 0, 0, 1'b0, lat, rd, er);
    run_txn(1'b0, 0, 3, 32'd0, 0, 0, 1'b0, lat, rd, er);
    run_txn(1'b0, 3, 1, 32'd0, 0, 0, 1'b0, lat, rd, er);
    run_txn(1'b1, 6, 2, 32'h1, 0, 0, 1'b0, lat, rd, er);
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; bit er;
    for (int i = 0; i < 60; i++) begin
      bit wr = 1'($urandom_range(0, 1));
      int sz = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
      int a  = int'($urandom_range(0, 252));
      bit he = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a = a & ~1;
        if (sz == 2) a = a & ~3;
      end
`ifdef AHB_MASTER_HRESP_EN
      he = ($urandom_range(0, 4) == 0);
`endif
      run_txn(wr, a, sz, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              he, lat, rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; bit er;
    for (int i = 0; i < 8; i++)
      run_txn(1'b1, 16 + 4 * i, 2, $urandom, 0, 0, 1'b0, lat, rd, er);
    for (int i = 0; i < 8; i++)
      run_txn(1'b0, 16 + 4 * i, 2, 32'd0, 0, 0, 1'b0, lat, rd, er);
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'd40;
    bus.cmd_size  = 3'b010;
    bus.cmd_wdata = 32'hA5A5_5A5A;
    bus.hready    = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.htrans !== 2'b00 || bus.hwdata !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL reset_mid_setup: got htrans=%b hwdata=%h expected 00 a5a55a5a", bus.htrans, bus.hwdata);
    end
    bus.hready = 1'b0;
    reset = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_after: got stray rsp_valid or cmd_ready low expected idle");
    end
  endtask

`ifdef AHB_MASTER_HRESP_EN
  task automatic test_hresp();
    int lat; logic [31:0] rd; bit er;
    run_txn(1'b0, 0, 2, 32'd0, 0, 0, 1'b1, lat, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0 || lat != 4) begin
      errors++;
      $display("FAIL hresp_error: got err=%b rdata=%h lat %0d expected 1 0 4", er, rd, lat);
    end
    run_txn(1'b1, 8, 2, 32'h0BAD_F00D, 1, 2, 1'b1, lat, rd, er);
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) begin
      smem[i] = 8'($urandom);
      gmem[i] = smem[i];
    end
    smem[0] = 8'hAA; smem[1] = 8'hBB; smem[2] = 8'hCC; smem[3] = 8'hDD; smem[4] = 8'hEE;
    for (int i = 0; i < 5; i++) gmem[i] = smem[i];
    @(negedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_illegal();
`ifdef AHB_MASTER_HRESP_EN
    test_hresp();
`endif
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end
endmodule
